// File: rtl/ctrl_pkg.sv
// Shared definitions for the decode-control consumer pipeline:
// control bundle layout, forwarding encodings and the forwarding selector.
package ctrl_pkg;

    localparam int unsigned CTRL_W = 10;

    // Bit positions inside the control bundle
    localparam int unsigned CB_ALUSRC     = 9;
    localparam int unsigned CB_MEM_TO_REG = 8;
    localparam int unsigned CB_REG_WRITE  = 7;
    localparam int unsigned CB_REG_DEST   = 6;
    localparam int unsigned CB_MEM_READ   = 5;
    localparam int unsigned CB_MEM_WRITE  = 4;
    localparam int unsigned CB_BRANCH     = 3;
    localparam int unsigned CB_JUMP       = 2;

    typedef struct packed {
        logic       alusrc;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dest;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Operand source for one EX source register; the younger MEM result wins over WB
    function automatic fwd_sel_e fwd_select(
        input logic       mem_valid,
        input logic       mem_reg_write,
        input logic [4:0] mem_rd,
        input logic       wb_valid,
        input logic       wb_reg_write,
        input logic [4:0] wb_rd,
        input logic [4:0] rs
    );
        if (mem_valid && mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs))
            return FWD_MEM;
        else if (wb_valid && wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// Generic pipeline stage register: hold keeps contents, bubble loads all-zero.
module ctrl_stage_reg #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_hold,
    input  logic         i_bubble,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Stage update: hold beats bubble so a frozen stage keeps its instruction
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_q <= '0;
        else if (i_hold)
            r_q <= r_q;
        else if (i_bubble)
            r_q <= '0;
        else
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/ctrl_pipeline.sv
// EX/MEM/WB control pipeline with load-use stall, EX redirect flush,
// operand forwarding selects and a saturating bubble counter.
module ctrl_pipeline #(
    parameter int unsigned CTRL_W = ctrl_pkg::CTRL_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              id_valid_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic [4:0]        id_rd_i,
    input  logic              ex_branch_cond_i,
    input  logic              mem_ready_i,
    output logic              ex_valid_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [4:0]        ex_rd_o,
    output logic              mem_valid_o,
    output logic [CTRL_W-1:0] mem_ctrl_o,
    output logic [4:0]        mem_rd_o,
    output logic              wb_valid_o,
    output logic              wb_reg_write_o,
    output logic              wb_mem_to_reg_o,
    output logic [4:0]        wb_rd_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    import ctrl_pkg::*;

    localparam int unsigned IDEX_W  = 1 + CTRL_W + 15;
    localparam int unsigned EXMEM_W = 1 + CTRL_W + 5;
    localparam int unsigned MEMWB_W = 1 + 1 + 1 + 5;

    logic [IDEX_W-1:0]  w_idex_d,  w_idex_q;
    logic [EXMEM_W-1:0] w_exmem_d, w_exmem_q;
    logic [MEMWB_W-1:0] w_memwb_d, w_memwb_q;

    logic              w_ex_valid;
    logic [CTRL_W-1:0] w_ex_ctrl;
    logic [4:0]        w_ex_rs1, w_ex_rs2, w_ex_rd;
    logic              w_mem_valid;
    logic [CTRL_W-1:0] w_mem_ctrl;
    logic [4:0]        w_mem_rd;
    logic              w_wb_valid, w_wb_reg_write, w_wb_mem_to_reg;
    logic [4:0]        w_wb_rd;

    logic w_freeze, w_redirect, w_loaduse, w_idex_bubble, w_count_bubble;
    logic w_stall, w_flush;
    logic [1:0] w_fwd_a, w_fwd_b;

    logic [CNT_W-1:0] r_bubble_cnt;

    assign w_idex_d  = {1'b1, id_ctrl_i, id_rs1_i, id_rs2_i, id_rd_i};
    assign {w_ex_valid, w_ex_ctrl, w_ex_rs1, w_ex_rs2, w_ex_rd} = w_idex_q;

    assign w_exmem_d = {w_ex_valid, w_ex_ctrl, w_ex_rd};
    assign {w_mem_valid, w_mem_ctrl, w_mem_rd} = w_exmem_q;

    assign w_memwb_d = {w_mem_valid, w_mem_ctrl[CB_REG_WRITE], w_mem_ctrl[CB_MEM_TO_REG], w_mem_rd};
    assign {w_wb_valid, w_wb_reg_write, w_wb_mem_to_reg, w_wb_rd} = w_memwb_q;

    // Hazard detection and per-cycle action selection
    always_comb begin
        w_freeze   = !mem_ready_i;
        w_redirect = w_ex_valid &&
                     ((w_ex_ctrl[CB_BRANCH] && ex_branch_cond_i) || w_ex_ctrl[CB_JUMP]);
        w_loaduse  = w_ex_valid && w_ex_ctrl[CB_MEM_READ] && (w_ex_rd != 5'd0) && id_valid_i &&
                     ((w_ex_rd == id_rs1_i) || (w_ex_rd == id_rs2_i));
        w_count_bubble = !w_freeze && (w_redirect || w_loaduse);
        w_idex_bubble  = w_redirect || w_loaduse || !id_valid_i;
        // Gated by reset so the freeze input cannot raise stall while the pipeline is cleared
        w_stall = rst_ni && (w_freeze || (w_loaduse && !w_redirect));
        w_flush = rst_ni && !w_freeze && w_redirect;
    end

    // Forwarding selects for both EX source operands
    always_comb begin
        w_fwd_a = fwd_select(w_mem_valid, w_mem_ctrl[CB_REG_WRITE], w_mem_rd,
                             w_wb_valid, w_wb_reg_write, w_wb_rd, w_ex_rs1);
        w_fwd_b = fwd_select(w_mem_valid, w_mem_ctrl[CB_REG_WRITE], w_mem_rd,
                             w_wb_valid, w_wb_reg_write, w_wb_rd, w_ex_rs2);
    end

    ctrl_stage_reg #(.W(IDEX_W)) u_idex (
        .i_clk    (clk_i),
        .i_rst_n  (rst_ni),
        .i_hold   (w_freeze),
        .i_bubble (w_idex_bubble),
        .i_d      (w_idex_d),
        .o_q      (w_idex_q)
    );

    ctrl_stage_reg #(.W(EXMEM_W)) u_exmem (
        .i_clk    (clk_i),
        .i_rst_n  (rst_ni),
        .i_hold   (w_freeze),
        .i_bubble (1'b0),
        .i_d      (w_exmem_d),
        .o_q      (w_exmem_q)
    );

    ctrl_stage_reg #(.W(MEMWB_W)) u_memwb (
        .i_clk    (clk_i),
        .i_rst_n  (rst_ni),
        .i_hold   (w_freeze),
        .i_bubble (1'b0),
        .i_d      (w_memwb_d),
        .o_q      (w_memwb_q)
    );

    // Saturating count of hazard bubbles (redirect or load-use, once per cycle)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_bubble_cnt <= '0;
        else if (w_count_bubble && (r_bubble_cnt != '1))
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end

    assign ex_valid_o      = w_ex_valid;
    assign ex_ctrl_o       = w_ex_ctrl;
    assign ex_rd_o         = w_ex_rd;
    assign mem_valid_o     = w_mem_valid;
    assign mem_ctrl_o      = w_mem_ctrl;
    assign mem_rd_o        = w_mem_rd;
    assign wb_valid_o      = w_wb_valid;
    assign wb_reg_write_o  = w_wb_reg_write;
    assign wb_mem_to_reg_o = w_wb_mem_to_reg;
    assign wb_rd_o         = w_wb_rd;
    assign stall_o         = w_stall;
    assign flush_o         = w_flush;
    assign fwd_a_o         = w_fwd_a;
    assign fwd_b_o         = w_fwd_b;
    assign bubble_cnt_o    = r_bubble_cnt;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed scenarios plus random traffic against a
// queue-style pipeline model; bubble counter narrowed to 4 bits to reach saturation.
module tb_ctrl_pipeline;

    localparam int NW = 4;
    localparam logic [9:0] ALU  = 10'h080;
    localparam logic [9:0] LD   = 10'h3A0;
    localparam logic [9:0] BR   = 10'h008;
    localparam logic [9:0] JMP  = 10'h004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [9:0]  id_ctrl = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        cond = 1'b0;
    logic        ready = 1'b1;

    logic        ex_valid_o, mem_valid_o, wb_valid_o, wb_reg_write_o, wb_mem_to_reg_o;
    logic [9:0]  ex_ctrl_o, mem_ctrl_o;
    logic [4:0]  ex_rd_o, mem_rd_o, wb_rd_o;
    logic        stall_o, flush_o;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic [NW-1:0] bubble_cnt_o;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ctrl_pipeline #(.CTRL_W(10), .CNT_W(NW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .id_valid_i       (id_valid),
        .id_ctrl_i        (id_ctrl),
        .id_rs1_i         (id_rs1),
        .id_rs2_i         (id_rs2),
        .id_rd_i          (id_rd),
        .ex_branch_cond_i (cond),
        .mem_ready_i      (ready),
        .ex_valid_o       (ex_valid_o),
        .ex_ctrl_o        (ex_ctrl_o),
        .ex_rd_o          (ex_rd_o),
        .mem_valid_o      (mem_valid_o),
        .mem_ctrl_o       (mem_ctrl_o),
        .mem_rd_o         (mem_rd_o),
        .wb_valid_o       (wb_valid_o),
        .wb_reg_write_o   (wb_reg_write_o),
        .wb_mem_to_reg_o  (wb_mem_to_reg_o),
        .wb_rd_o          (wb_rd_o),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .fwd_a_o          (fwd_a_o),
        .fwd_b_o          (fwd_b_o),
        .bubble_cnt_o     (bubble_cnt_o)
    );

    // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB, each a whole instruction
    typedef struct {
        bit       v;
        bit [9:0] c;
        bit [4:0] rs1, rs2, rd;
    } ent_t;

    ent_t pipe [3];
    int   m_cnt = 0;
    bit   e_frz, e_redir, e_lu;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int src(input bit [4:0] r);
        if (pipe[1].v && pipe[1].c[7] && pipe[1].rd != 0 && pipe[1].rd == r) return 2;
        if (pipe[2].v && pipe[2].c[7] && pipe[2].rd != 0 && pipe[2].rd == r) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
        m_cnt = 0;
    endtask

    // Let inputs settle, then compare every output against the model
    task automatic settle();
        #1;
        e_frz   = !ready;
        e_redir = pipe[0].v && ((pipe[0].c[3] && cond) || pipe[0].c[2]);
        e_lu    = pipe[0].v && pipe[0].c[5] && pipe[0].rd != 0 && id_valid &&
                  (pipe[0].rd == id_rs1 || pipe[0].rd == id_rs2);
        chk("ex_valid",  ex_valid_o,  pipe[0].v);
        chk("ex_ctrl",   ex_ctrl_o,   pipe[0].c);
        chk("ex_rd",     ex_rd_o,     pipe[0].rd);
        chk("mem_valid", mem_valid_o, pipe[1].v);
        chk("mem_ctrl",  mem_ctrl_o,  pipe[1].c);
        chk("mem_rd",    mem_rd_o,    pipe[1].rd);
        chk("wb_valid",  wb_valid_o,  pipe[2].v);
        chk("wb_rw",     wb_reg_write_o,  pipe[2].c[7]);
        chk("wb_m2r",    wb_mem_to_reg_o, pipe[2].c[8]);
        chk("wb_rd",     wb_rd_o,     pipe[2].rd);
        chk("stall",     stall_o,     e_frz || (e_lu && !e_redir));
        chk("flush",     flush_o,     !e_frz && e_redir);
        chk("fwd_a",     fwd_a_o,     src(pipe[0].rs1));
        chk("fwd_b",     fwd_b_o,     src(pipe[0].rs2));
        chk("bubble_cnt", bubble_cnt_o, m_cnt);
    endtask

    // Apply the clock edge to the model, then move to just after the DUT edge
    task automatic adv();
        if (!e_frz) begin
            if (e_redir || e_lu) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (e_redir || e_lu || !id_valid) pipe[0] = '{default: 0};
            else pipe[0] = '{v: 1'b1, c: id_ctrl, rs1: id_rs1, rs2: id_rs2, rd: id_rd};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit [9:0] c, input bit [4:0] a, input bit [4:0] b,
                         input bit [4:0] d);
        id_valid = v; id_ctrl = c; id_rs1 = a; id_rs2 = b; id_rd = d;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_ex_valid", ex_valid_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_cnt", bubble_cnt_o, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Four independent ALU ops, each reaching WB three cycles after issue
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1, ALU, 5'd0, 5'd0, 5'(i + 1));
            else       drive(0, '0, 5'd0, 5'd0, 5'd0);
            settle();
            if (i >= 3) chk("alu_wb_latency", wb_rd_o, i - 2);
            chk("alu_no_stall", stall_o, 0);
            chk("alu_no_flush", flush_o, 0);
            adv();
        end
        chk("alu_cnt_zero", bubble_cnt_o, 0);

        // Load x5 then add x6,x5,x7: one stall, then WB forwarding
        drive(1, LD, 5'd1, 5'd0, 5'd5); step();
        drive(1, ALU, 5'd5, 5'd7, 5'd6); settle();
        chk("lu_stall", stall_o, 1);
        adv();
        settle();
        chk("lu_stall_once", stall_o, 0);
        chk("lu_cnt", bubble_cnt_o, 1);
        adv();
        drive(0, '0, 0, 0, 0); settle();
        chk("lu_fwd_a_wb", fwd_a_o, 1);
        adv();

        // Back-to-back dependency forwards from MEM
        drive(1, ALU, 5'd1, 5'd2, 5'd3); step();
        drive(1, ALU, 5'd3, 5'd3, 5'd4); step();
        drive(0, '0, 0, 0, 0); settle();
        chk("fwd_mem_a", fwd_a_o, 2);
        chk("fwd_mem_b", fwd_b_o, 2);
        adv();
        // One independent op between: forwards from WB
        drive(1, ALU, 5'd1, 5'd2, 5'd3); step();
        drive(1, ALU, 5'd1, 5'd2, 5'd9); step();
        drive(1, ALU, 5'd3, 5'd3, 5'd4); step();
        drive(0, '0, 0, 0, 0); settle();
        chk("fwd_wb_a", fwd_a_o, 1);
        chk("fwd_wb_b", fwd_b_o, 1);
        adv();

        // Taken branch flushes and discards the ID instruction
        drive(1, BR, 5'd1, 5'd2, 5'd0); step();
        drive(1, ALU, 5'd1, 5'd2, 5'd10); cond = 1'b1; settle();
        chk("br_taken_flush", flush_o, 1);
        chk("br_taken_stall", stall_o, 0);
        adv();
        drive(0, '0, 0, 0, 0); cond = 1'b0; settle();
        chk("br_id_killed", ex_valid_o, 0);
        adv();
        // Not-taken branch
        drive(1, BR, 5'd1, 5'd2, 5'd0); step();
        drive(1, ALU, 5'd1, 5'd2, 5'd11); settle();
        chk("br_not_taken", flush_o, 0);
        adv();
        // Jump with cond=0 still redirects
        drive(1, JMP, 5'd0, 5'd0, 5'd0); step();
        drive(0, '0, 0, 0, 0); settle();
        chk("jump_flush", flush_o, 1);
        adv();

        // Freeze with a taken branch in EX
        drive(1, BR, 5'd1, 5'd2, 5'd0); step();
        drive(1, ALU, 5'd1, 5'd2, 5'd12); cond = 1'b1; ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("frz_stall", stall_o, 1);
            chk("frz_flush", flush_o, 0);
            chk("frz_ex_hold", ex_ctrl_o, BR);
            adv();
        end
        ready = 1'b1; settle();
        chk("frz_release_flush", flush_o, 1);
        adv();
        cond = 1'b0;

        // Asynchronous reset mid-stream
        drive(1, ALU, 5'd1, 5'd2, 5'd13); step();
        drive(1, LD, 5'd1, 5'd2, 5'd14); ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", ex_valid_o, 0);
        chk("arst_mem_valid", mem_valid_o, 0);
        chk("arst_wb_rd", wb_rd_o, 0);
        chk("arst_stall", stall_o, 0);
        chk("arst_flush", flush_o, 0);
        chk("arst_cnt", bubble_cnt_o, 0);
        model_reset();
        drive(0, '0, 0, 0, 0); ready = 1'b1;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Twenty load-use events saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(1, LD, 5'd1, 5'd0, 5'd5); step();
            drive(1, ALU, 5'd5, 5'd7, 5'd6); step();
            step();
        end
        drive(0, '0, 0, 0, 0); settle();
        chk("cnt_saturated", bubble_cnt_o, 15);
        adv();

        // Random traffic; small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            bit [9:0] c;
            c = 10'($urandom);
            if ($urandom_range(3) != 0) c[2] = 1'b0;
            drive(1'($urandom_range(1)), c, 5'($urandom_range(7)), 5'($urandom_range(7)),
                  5'($urandom_range(7)));
            cond  = 1'($urandom_range(1));
            ready = ($urandom_range(4) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Consumer side of the decode control bundle. Registers the decoder's control bits and carries them through the EX, MEM and WB stages, and detects load-use hazards and EX-resolved branch/jump redirects. It generates stall, flush and forwarding-select signals for the datapath. It sits between the decode-stage control unit and the EX/MEM/WB datapath.

## Interface
Parameters:
- CTRL_W, 10: control bundle width. Bit order: [9] alusrc, [8] mem_to_reg, [7] reg_write, [6] reg_dest, [5] mem_read, [4] mem_write, [3] branch, [2] jump, [1:0] alu_op.
- CNT_W, 16: bubble counter width.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- id_valid_i  in  1  decode slot holds a real instruction.
- id_ctrl_i  in  CTRL_W  control bundle from the decoder.
- id_rs1_i, id_rs2_i, id_rd_i  in  5 each  register indices of the decode instruction.
- ex_branch_cond_i  in  1  ALU branch comparison result for the EX instruction.
- mem_ready_i  in  1  data memory ready; 0 freezes the pipeline.
- ex_valid_o, ex_ctrl_o, ex_rd_o  out  1/CTRL_W/5  EX stage state.
- mem_valid_o, mem_ctrl_o, mem_rd_o  out  1/CTRL_W/5  MEM stage state.
- wb_valid_o, wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o  out  1/1/1/5  WB stage state.
- stall_o  out  1  hold PC and IF/ID.
- flush_o  out  1  kill IF/ID; redirect PC.
- fwd_a_o, fwd_b_o  out  2 each  EX operand source: 00 = regfile, 01 = WB, 10 = MEM.
- bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles.

## Operation
- Stage registers: ID/EX (valid, ctrl, rs1, rs2, rd), EX/MEM (valid, ctrl, rd), MEM/WB (valid, reg_write, mem_to_reg, rd).
- Bubble: valid=0, ctrl all zero, rd=0. Downstream reg_write and mem_write are therefore never asserted for a bubble.
- Signal definitions:
  - freeze = !mem_ready_i.
  - redirect = ex_valid & ((ctrl.branch & ex_branch_cond_i) | ctrl.jump).
  - loaduse = ex_valid & ctrl.mem_read & ex_rd != 0 & id_valid_i & (ex_rd == id_rs1_i | ex_rd == id_rs2_i).
- Per-cycle action, in priority order:
  1. freeze: all stage registers hold; stall_o=1; flush_o=0; bubble_cnt holds.
  2. redirect: flush_o=1; stall_o=0; ID/EX loads a bubble; EX→MEM→WB advance; bubble_cnt +1.
  3. loaduse: stall_o=1; flush_o=0; ID/EX loads a bubble; EX→MEM→WB advance; bubble_cnt +1.
  4. Otherwise: all stages advance. ID/EX loads id_ctrl_i when id_valid_i=1; when id_valid_i=0 it loads a bubble, which does not count.
- Forwarding, fwd_a_o (fwd_b_o is the same with ex_rs2):
  - 10 if mem_valid & mem.reg_write & mem_rd != 0 & mem_rd == ex_rs1.
  - else 01 if wb_valid & wb_reg_write & wb_rd != 0 & wb_rd == ex_rs1.
  - else 00.
  - MEM takes priority over WB.
- bubble_cnt saturates at all-ones and never wraps.

## Timing
- Reset: all valid, ctrl, rd, rs fields are 0; stall_o=0, flush_o=0, fwd_*=00, bubble_cnt_o=0. Reset asserted mid-operation clears all of these immediately, asynchronously.
- Latency: decode bundle appears on ex_* 1 cycle after capture, mem_* after 2, wb_* after 3.
- stall_o, flush_o and fwd_*_o are combinational from registered state and the current inputs; they are valid in the same cycle.
- Load-use costs exactly one bubble. On the following cycle the load is in MEM, loaduse is false, and fwd selects 10 or 01 as appropriate.
- A redirect is honored only in a non-freeze cycle. While frozen, the EX instruction holds, so the redirect is applied on the first cycle mem_ready_i=1.
- Redirect coinciding with loaduse: the flush wins, no stall, and exactly one bubble is counted.
- A redirect bubble also discards the ID instruction. The IF/ID register is killed externally via flush_o.

## Structure
- Shared package ctrl_pkg holds:
  - Control bit-position constants or a packed struct (alusrc … alu_op).
  - The forwarding encodings FWD_RF/FWD_WB/FWD_MEM.
  - CTRL_W.
- Sub-module ctrl_stage_reg: one parameterized stage register with hold and bubble inputs. Instantiated three times.
- Hazard, forwarding and redirect logic are combinational in the top module.

## Test plan
- Reset, then stream 4 independent ALU ops (reg_write=1, rd=1..4) → each appears on wb_* 3 cycles after issue; stall_o and flush_o stay 0; bubble_cnt=0.
- Load to x5, then `add x6,x5,x7` → stall_o=1 for 1 cycle and an EX bubble is inserted. On the next cycle fwd_a_o=01 (load now in WB); bubble_cnt=1.
- `add x3`, then `sub x4,x3,x3` → fwd_a_o=fwd_b_o=10 in the sub's EX cycle. With an independent op in between → 01.
- Branch in EX with ex_branch_cond_i=1 → flush_o=1 for 1 cycle and the ID instruction becomes a bubble. With ex_branch_cond_i=0 → no flush. A jump with cond=0 → flush.
- Hold mem_ready_i=0 for 3 cycles with a taken branch in EX → all stages hold, stall_o=1, flush_o=0. flush_o=1 on the first ready cycle.
- Assert rst_ni low mid-stream → all outputs are zero asynchronously. Force bubble_cnt near max (CNT_W=4, 20 load-use events) → saturates at 15.
